hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning consecutive DWAIT cycles before timeout asserts.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the stall_cycles counter.
REQ-003 SHALL have port CLK  input  1  rising-edge clock, the block's only clock.
REQ-004 SHALL have port nRST  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports id_rs, id_rt  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have port id_uses_rt  input  1  instruction in ID reads rt.
REQ-007 SHALL have ports ex_rd  input  5 and ex_memRead  input  1  destination register and load flag of the instruction in EX.
REQ-008 SHALL have ports mem_req  input  1 (dREN|dWEN in MEM) and dhit  input  1 (data access complete).
REQ-009 SHALL have ports ihit  input  1  instruction fetch complete; branch_taken  input  1  branch/jump resolved taken in EX; halt  input  1  halt in MEM.
REQ-010 SHALL have outputs pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  1 each  stage-register enables.
REQ-011 SHALL have outputs if_id_flush, id_ex_flush  1 each  load bubble into stage.
REQ-012 SHALL have outputs state  2 (RUN=0, DWAIT=1, LUSTALL=2, HALTED=3), stall_cycles  CNT_W, timeout  1.

Function
REQ-013 Enable/flush outputs SHALL be combinational from state and inputs; state, stall_cycles, timeout and wait counter SHALL be registered.
REQ-014 Default (no condition active, state not HALTED): all enables 1, both flushes 0.
REQ-015 Priority, highest first: HALTED > data wait > load-use > branch_taken > !ihit.
REQ-016 Data wait (mem_req && !dhit): all enables 0, flushes 0; next state DWAIT.
REQ-017 Load-use (ex_memRead && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt))): pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1; next state LUSTALL.
REQ-018 branch_taken: all enables 1, if_id_flush=1, id_ex_flush=1; next state RUN.
REQ-019 !ihit: pc_en=0, if_id_flush=1, other enables 1; next state RUN.
REQ-020 Load-use with ex_rd==0 SHALL NOT stall.
REQ-021 Load-use stall SHALL last exactly one cycle per load; LUSTALL with no new condition returns to RUN.
REQ-022 DWAIT SHALL persist while mem_req && !dhit; the cycle dhit=1 applies lower-priority rules and leaves DWAIT.
REQ-023 Wait counter SHALL count consecutive cycles in DWAIT, clear on exit, and saturate at MAX_WAIT.
REQ-024 timeout SHALL set when the wait counter reaches MAX_WAIT and SHALL stay set (sticky) until reset.
REQ-025 stall_cycles SHALL increment on every cycle with pc_en=0 and state!=HALTED, saturating at all-ones.
REQ-026 halt=1 in any non-HALTED cycle SHALL complete that cycle's normal outputs, then enter HALTED next cycle.
REQ-027 HALTED: all enables 0, flushes 0; SHALL stay HALTED until reset regardless of inputs.
REQ-028 Simultaneous branch_taken and load-use SHALL resolve as load-use; the branch stays in EX and is taken the next cycle.

Reset
REQ-029 nRST=0 at a rising edge SHALL set state=RUN, stall_cycles=0, timeout=0, and wait counter=0.
REQ-030 While nRST=0: all enables 0, both flushes 1, overriding every other condition including mid-stall and HALTED.

Verification
REQ-031 Load-use: ex_memRead=1, ex_rd=8, id_rs=8 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1; next cycle state=LUSTALL; stall_cycles=1.
REQ-032 Data wait: mem_req=1, dhit=0 for 3 cycles, then dhit=1 -> enables 0 for 3 cycles, state=DWAIT, all 1 on dhit cycle; timeout=0.
REQ-033 Timeout: mem_req=1, dhit=0 for 20 cycles, MAX_WAIT=15 -> timeout=1 from cycle 16 onward and stays 1 after dhit=1.
REQ-034 Branch plus ihit=0 together -> if_id_flush=1, id_ex_flush=1, pc_en=1.
REQ-035 halt=1 then random inputs for 10 cycles -> state=3, enables 0, stall_cycles frozen; nRST=0 -> state=0, counter=0.
REQ-036 Load-use with ex_rd=0, id_rs=0 -> no stall, all enables 1.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard unit interface: pipeline status in, stage enables/flushes and status out.
interface hazard_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       ex_rd;
  logic             ex_memRead;
  logic             mem_req;
  logic             dhit;
  logic             ihit;
  logic             branch_taken;
  logic             halt;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic             timeout;

  // Pipeline side: drives status, consumes control
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rd, ex_memRead, mem_req, dhit, ihit, branch_taken, halt,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
    input  state, stall_cycles, timeout
  );

  // Hazard unit side
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rd, ex_memRead, mem_req, dhit, ihit, branch_taken, halt,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
    output state, stall_cycles, timeout
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: data-wait, load-use, branch and fetch-miss handling,
// halt latch, stall statistics and a sticky data-wait timeout flag.
module hazard_unit #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input logic          CLK,
  input logic          nRST,
  hazard_unit_if.slave hif
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StDwait   = 2'd1,
    StLustall = 2'd2,
    StHalted  = 2'd3
  } state_e;

  localparam int unsigned WaitW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush;
  logic data_wait, load_use;

  assign data_wait = hif.mem_req && !hif.dhit;
  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use  = hif.ex_memRead && (hif.ex_rd != 5'd0) &&
                     ((hif.ex_rd == hif.id_rs) || (hif.id_uses_rt && (hif.ex_rd == hif.id_rt)));

  // Stage controls and next state, highest-priority condition wins
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_d     = StRun;
    if (!nRST) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == StHalted) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      state_d = StHalted;
    end else begin
      if (data_wait) begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
        state_d = StDwait;
      end else if (load_use) begin
        // Hold PC and IF/ID, drop a bubble into EX; a taken branch in EX waits a cycle
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        state_d     = StLustall;
      end else if (hif.branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (!hif.ihit) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
      // Halt lets this cycle's controls stand and parks the pipeline afterwards
      if (hif.halt) state_d = StHalted;
    end
  end

  // Wait counter, sticky timeout and stall statistics next-state
  always_comb begin
    wait_cnt_d = '0;
    if (state_d == StDwait) begin
      wait_cnt_d = (wait_cnt_q >= WaitMax) ? WaitMax : wait_cnt_q + 1'b1;
    end
    timeout_d      = timeout_q || (wait_cnt_d >= WaitMax);
    stall_cycles_d = stall_cycles_q;
    if (!pc_en && (state_q != StHalted) && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q        <= StRun;
      stall_cycles_q <= '0;
      wait_cnt_q     <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      wait_cnt_q     <= wait_cnt_d;
      timeout_q      <= timeout_d;
    end
  end

  assign hif.pc_en        = pc_en;
  assign hif.if_id_en     = if_id_en;
  assign hif.id_ex_en     = id_ex_en;
  assign hif.ex_mem_en    = ex_mem_en;
  assign hif.mem_wb_en    = mem_wb_en;
  assign hif.if_id_flush  = if_id_flush;
  assign hif.id_ex_flush  = id_ex_flush;
  assign hif.state        = state_q;
  assign hif.stall_cycles = stall_cycles_q;
  assign hif.timeout      = timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: expected per-cycle outputs are queued as
// stimulus is driven and popped/compared mid-cycle on the falling edge.
module tb_hazard_unit;

  localparam int unsigned CntW = 16;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
  localparam logic [6:0] CtlRun  = 7'b11111_00;
  localparam logic [6:0] CtlDw   = 7'b00000_00;
  localparam logic [6:0] CtlLu   = 7'b00111_01;
  localparam logic [6:0] CtlBr   = 7'b11111_11;
  localparam logic [6:0] CtlIm   = 7'b01111_10;
  localparam logic [6:0] CtlHalt = 7'b00000_00;
  localparam logic [6:0] CtlRst  = 7'b00000_11;

  typedef struct {
    string       name;
    logic [25:0] w;
  } exp_t;

  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_fail;
  exp_t sb[$];

  hazard_unit_if #(.CNT_W(CntW)) hif ();

  hazard_unit #(
    .MAX_WAIT(15),
    .CNT_W   (CntW)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .hif (hif)
  );

  always #5 CLK = ~CLK;

  function automatic logic [25:0] obs_word();
    return {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en, hif.mem_wb_en,
            hif.if_id_flush, hif.id_ex_flush, hif.state, hif.timeout, hif.stall_cycles};
  endfunction

  task automatic push(input string nm, input logic [6:0] ctl, input logic [1:0] st,
                      input logic to, input int sc);
    exp_t e;
    e.name = nm;
    e.w    = {ctl, st, to, sc[15:0]};
    sb.push_back(e);
  endtask

  task automatic idle();
    hif.id_rs        = 5'd1;
    hif.id_rt        = 5'd2;
    hif.id_uses_rt   = 1'b0;
    hif.ex_rd        = 5'd0;
    hif.ex_memRead   = 1'b0;
    hif.mem_req      = 1'b0;
    hif.dhit         = 1'b0;
    hif.ihit         = 1'b1;
    hif.branch_taken = 1'b0;
    hif.halt         = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs);
    hif.ex_memRead = 1'b1;
    hif.ex_rd      = rd;
    hif.id_rs      = rs;
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      idle();
      case (i)
        1: begin hif.mem_req = 1'b1; push("rst_pre_wait1", CtlDw, 2'd0, 1'b0, 0); end
        2: begin hif.mem_req = 1'b1; push("rst_pre_wait2", CtlDw, 2'd1, 1'b0, 1); end
        3: begin nRST = 1'b0; hif.mem_req = 1'b1; push("rst_mid_stall", CtlRst, 2'd1, 1'b0, 2); end
        4: begin
          nRST = 1'b0; hif.halt = 1'b1; set_lu(5'd4, 5'd4);
          push("rst_held", CtlRst, 2'd0, 1'b0, 0);
        end
        default: begin nRST = 1'b1; push("rst_release", CtlRun, 2'd0, 1'b0, 0); end
      endcase
      @(negedge CLK);
      e = sb.pop_front();
      n_cmp++;
      if (obs_word() !== e.w) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs_word(), e.w);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      idle();
      case (i)
        1: begin set_lu(5'd8, 5'd8); push("lu_rs", CtlLu, 2'd0, 1'b0, 0); end
        2: push("lu_stall_state", CtlRun, 2'd2, 1'b0, 1);
        3: push("lu_back_run", CtlRun, 2'd0, 1'b0, 1);
        4: begin
          set_lu(5'd9, 5'd3); hif.id_rt = 5'd9; hif.id_uses_rt = 1'b1;
          push("lu_rt", CtlLu, 2'd0, 1'b0, 1);
        end
        5: begin
          set_lu(5'd9, 5'd3); hif.id_rt = 5'd9;
          push("lu_rt_unused", CtlRun, 2'd2, 1'b0, 2);
        end
        default: push("lu_idle", CtlRun, 2'd0, 1'b0, 2);
      endcase
      @(negedge CLK);
      e = sb.pop_front();
      n_cmp++;
      if (obs_word() !== e.w) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs_word(), e.w);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_rd_zero();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      idle();
      if (i == 1) begin
        set_lu(5'd0, 5'd0);
        push("rd0_no_stall", CtlRun, 2'd0, 1'b0, 0);
      end else begin
        push("rd0_state_run", CtlRun, 2'd0, 1'b0, 0);
      end
      @(negedge CLK);
      e = sb.pop_front();
      n_cmp++;
      if (obs_word() !== e.w) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs_word(), e.w);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_data_wait();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      idle();
      if (i <= 3) begin
        hif.mem_req = 1'b1;
        push("dwait", CtlDw, (i == 1) ? 2'd0 : 2'd1, 1'b0, i - 1);
      end else if (i == 4) begin
        hif.mem_req = 1'b1;
        hif.dhit    = 1'b1;
        push("dwait_hit", CtlRun, 2'd1, 1'b0, 3);
      end else begin
        push("dwait_exit", CtlRun, 2'd0, 1'b0, 3);
      end
      @(negedge CLK);
      e = sb.pop_front();
      n_cmp++;
      if (obs_word() !== e.w) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs_word(), e.w);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 23; i++) begin
      idle();
      if (i <= 20) begin
        hif.mem_req = 1'b1;
        push($sformatf("timeout_wait%0d", i), CtlDw, (i == 1) ? 2'd0 : 2'd1, (i >= 16), i - 1);
      end else if (i == 21) begin
        hif.mem_req = 1'b1;
        hif.dhit    = 1'b1;
        push("timeout_hit", CtlRun, 2'd1, 1'b1, 20);
      end else if (i == 22) begin
        push("timeout_sticky", CtlRun, 2'd0, 1'b1, 20);
      end else begin
        hif.mem_req = 1'b1;
        push("timeout_rewait", CtlDw, 2'd0, 1'b1, 20);
      end
      @(negedge CLK);
      e = sb.pop_front();
      n_cmp++;
      if (obs_word() !== e.w) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs_word(), e.w);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_branch();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      idle();
      case (i)
        1: begin
          hif.branch_taken = 1'b1; hif.ihit = 1'b0;
          push("br_and_imiss", CtlBr, 2'd0, 1'b0, 0);
        end
        2: begin hif.ihit = 1'b0; push("imiss", CtlIm, 2'd0, 1'b0, 0); end
        3: push("br_idle", CtlRun, 2'd0, 1'b0, 1);
        4: begin
          hif.branch_taken = 1'b1; set_lu(5'd8, 5'd8);
          push("br_vs_lu", CtlLu, 2'd0, 1'b0, 1);
        end
        5: begin hif.branch_taken = 1'b1; push("br_after_lu", CtlBr, 2'd2, 1'b0, 2); end
        6: push("br_idle2", CtlRun, 2'd0, 1'b0, 2);
        7: begin
          hif.mem_req = 1'b1; set_lu(5'd5, 5'd5); hif.branch_taken = 1'b1;
          push("dw_vs_lu", CtlDw, 2'd0, 1'b0, 2);
        end
        8: push("dw_exit", CtlRun, 2'd1, 1'b0, 3);
        default: push("br_final", CtlRun, 2'd0, 1'b0, 3);
      endcase
      @(negedge CLK);
      e = sb.pop_front();
      n_cmp++;
      if (obs_word() !== e.w) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs_word(), e.w);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_halt();
    exp_t e;
    do_reset();
    for (int i = 1; i <= 13; i++) begin
      idle();
      if (i == 1) begin
        hif.halt = 1'b1;
        set_lu(5'd7, 5'd7);
        push("halt_entry", CtlLu, 2'd0, 1'b0, 0);
      end else if (i <= 12) begin
        hif.id_rs        = 5'($urandom);
        hif.id_rt        = 5'($urandom);
        hif.id_uses_rt   = 1'($urandom);
        hif.ex_rd        = 5'($urandom);
        hif.ex_memRead   = 1'($urandom);
        hif.mem_req      = 1'($urandom);
        hif.dhit         = 1'($urandom);
        hif.ihit         = 1'($urandom);
        hif.branch_taken = 1'($urandom);
        hif.halt         = 1'($urandom);
        if (i == 12) begin
          nRST = 1'b0;
          push("halt_reset", CtlRst, 2'd3, 1'b0, 1);
        end else begin
          push($sformatf("halted%0d", i), CtlHalt, 2'd3, 1'b0, 1);
        end
      end else begin
        nRST = 1'b1;
        push("halt_released", CtlRun, 2'd0, 1'b0, 0);
      end
      @(negedge CLK);
      e = sb.pop_front();
      n_cmp++;
      if (obs_word() !== e.w) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.name, obs_word(), e.w);
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    CLK    = 1'b0;
    nRST   = 1'b0;
    n_cmp  = 0;
    n_fail = 0;
    idle();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    nRST = 1'b1;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_data_wait();
    test_timeout();
    test_branch();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
